// File: rtl/luna_alu_pkg.sv
// Shared types and constants for the Luna 16-bit ALU.
// Optional overflow flag is enabled with LUNA_ALU_OVERFLOW_EN.
package luna_alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_OR  = 2'd1,
        ALU_ADD = 2'd2,
        ALU_SUB = 2'd3
    } alu_op_e;

    localparam logic [ALU_WIDTH-1:0] ALU_RESULT_RST = '0;

    // Signed overflow from operand/result sign bits; SUB compares against the
    // un-inverted Y sign, so the "signs equal" test flips for subtraction.
    function automatic logic alu_signed_ovf(input alu_op_e op, input logic a_msb,
                                            input logic b_msb, input logic r_msb);
        logic ovf;
        ovf = 1'b0;
        unique case (op)
            ALU_ADD: ovf = (a_msb == b_msb) && (r_msb != a_msb);
            ALU_SUB: ovf = (a_msb != b_msb) && (r_msb != a_msb);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/luna_alu_func.sv
// Combinational ALU function path: operand zeroing, operation select, output negation.
// Produces the overflow bit only when LUNA_ALU_OVERFLOW_EN is defined.
module luna_alu_func
    import luna_alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] x_i,
    input  logic [ALU_WIDTH-1:0] y_i,
    input  logic                 zero_x_i,
    input  logic                 zero_y_i,
    input  logic                 negate_i,
    input  logic [1:0]           op_i,
`ifdef LUNA_ALU_OVERFLOW_EN
    output logic                 ovf_o,
`endif
    output logic [ALU_WIDTH-1:0] d_o
);

    alu_op_e              op;
    logic [ALU_WIDTH-1:0] xe;
    logic [ALU_WIDTH-1:0] ye;
    logic [ALU_WIDTH-1:0] r;

    assign op = alu_op_e'(op_i);
    assign xe = zero_x_i ? '0 : x_i;
    assign ye = zero_y_i ? '0 : y_i;

    // Carry-out is intentionally dropped: arithmetic wraps modulo 2^16.
    always_comb begin
        r = '0;
        unique case (op)
            ALU_AND: r = xe & ye;
            ALU_OR:  r = xe | ye;
            ALU_ADD: r = xe + ye;
            ALU_SUB: r = xe + (~ye) + {{(ALU_WIDTH-1){1'b0}}, 1'b1};
            default: r = '0;
        endcase
    end

    assign d_o = negate_i ? ~r : r;

`ifdef LUNA_ALU_OVERFLOW_EN
    // Evaluated on r, before the optional inversion.
    assign ovf_o = alu_signed_ovf(op, xe[ALU_WIDTH-1], ye[ALU_WIDTH-1], r[ALU_WIDTH-1]);
`endif

endmodule

// File: rtl/luna_alu.sv
// Registered 16-bit Luna ALU: result register plus zero/negative flags.
// Define LUNA_ALU_OVERFLOW_EN to add the registered is_overflow output.
module luna_alu
    import luna_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ALU_WIDTH-1:0] x,
    input  logic [ALU_WIDTH-1:0] y,
    input  logic                 zero_x,
    input  logic                 zero_y,
    input  logic                 negate_output,
    input  logic [1:0]           opcode,
    output logic [ALU_WIDTH-1:0] output_result,
    output logic                 is_zero,
`ifdef LUNA_ALU_OVERFLOW_EN
    output logic                 is_overflow,
`endif
    output logic                 is_negative
);

    logic [ALU_WIDTH-1:0] result_d;
    logic [ALU_WIDTH-1:0] result_q;

`ifdef LUNA_ALU_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;
`endif

    luna_alu_func u_func (
        .x_i      (x),
        .y_i      (y),
        .zero_x_i (zero_x),
        .zero_y_i (zero_y),
        .negate_i (negate_output),
        .op_i     (opcode),
`ifdef LUNA_ALU_OVERFLOW_EN
        .ovf_o    (overflow_d),
`endif
        .d_o      (result_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= ALU_RESULT_RST;
        end else begin
            result_q <= result_d;
        end
    end

`ifdef LUNA_ALU_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign is_overflow = overflow_q;
`endif

    // Flags come from the registered value so they always match output_result.
    assign output_result = result_q;
    assign is_zero       = (result_q == '0);
    assign is_negative   = result_q[ALU_WIDTH-1];

endmodule

// File: tb/tb_luna_alu.sv
// Scoreboard bench for luna_alu; also exercises is_overflow under LUNA_ALU_OVERFLOW_EN.
module tb_luna_alu;
    import luna_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        zero_x = 1'b0;
    logic        zero_y = 1'b0;
    logic        negate_output = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic [15:0] output_result;
    logic        is_zero;
    logic        is_negative;
`ifdef LUNA_ALU_OVERFLOW_EN
    logic        is_overflow;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];

    luna_alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .x             (x),
        .y             (y),
        .zero_x        (zero_x),
        .zero_y        (zero_y),
        .negate_output (negate_output),
        .opcode        (opcode),
        .output_result (output_result),
        .is_zero       (is_zero),
`ifdef LUNA_ALU_OVERFLOW_EN
        .is_overflow   (is_overflow),
`endif
        .is_negative   (is_negative)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic za,
                                   input logic zb, input logic neg, input logic [1:0] op);
        logic [15:0] xe, ye, r, d;
        exp_t e;
        xe = za ? 16'h0000 : a;
        ye = zb ? 16'h0000 : b;
        e.ov = 1'b0;
        case (op)
            2'd0: r = xe & ye;
            2'd1: r = xe | ye;
            2'd2: begin
                r = xe + ye;
                e.ov = (xe[15] == ye[15]) && (r[15] != xe[15]);
            end
            default: begin
                r = xe - ye;
                e.ov = (xe[15] != ye[15]) && (r[15] != xe[15]);
            end
        endcase
        d = neg ? ~r : r;
        e.res = d;
        e.z = (d == 16'h0000);
        e.n = d[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a new operation at the falling edge and queue its expected result.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic za,
                         input logic zb, input logic neg, input logic [1:0] op);
        @(negedge clk);
        x = a;
        y = b;
        zero_x = za;
        zero_y = zb;
        negate_output = neg;
        opcode = op;
        sb_q.push_back(model(a, b, za, zb, neg, op));
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_res"}, output_result, e.res);
            chk({tag, "_zero"}, {15'd0, is_zero}, {15'd0, e.z});
            chk({tag, "_neg"}, {15'd0, is_negative}, {15'd0, e.n});
`ifdef LUNA_ALU_OVERFLOW_EN
            chk({tag, "_ovf"}, {15'd0, is_overflow}, {15'd0, e.ov});
`endif
        end
    endtask

    initial begin
        // Reset held from time zero
        @(posedge clk);
        #1;
        chk("rst_res", output_result, 16'h0000);
        chk("rst_zero", {15'd0, is_zero}, 16'd1);
        chk("rst_neg", {15'd0, is_negative}, 16'd0);
`ifdef LUNA_ALU_OVERFLOW_EN
        chk("rst_ovf", {15'd0, is_overflow}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        apply(16'h0002, 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        step("add_2_5");
        chk("add_2_5_lit", output_result, 16'h0007);

        // Glitch on x between edges; only the value at the edge counts
        apply(16'h0010, 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        #1 chk("hold_before_edge", output_result, 16'h0007);
        x = 16'h1234;
        #1 chk("glitch_no_effect", output_result, 16'h0007);
        x = 16'h0010;
        step("add_10_5");
        chk("add_10_5_lit", output_result, 16'h0015);

        // Asynchronous reset between edges discards the in-flight op
        apply(16'h0100, 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_res", output_result, 16'h0000);
        chk("async_rst_zero", {15'd0, is_zero}, 16'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 chk("rst_held_res", output_result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_released_no_edge", output_result, 16'h0000);
        sb_q.push_back(model(16'h0100, 16'h0005, 1'b0, 1'b0, 1'b0, 2'd2));
        step("post_rst");
        chk("post_rst_lit", output_result, 16'h0105);

        apply(16'h0010, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd2);
        step("zero_x");
        chk("zero_x_lit", output_result, 16'h0005);
        apply(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd2);
        step("zero_res");
        chk("zero_res_flag", {15'd0, is_zero}, 16'd1);
        apply(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2);
        step("negate");
        chk("negate_lit", output_result, 16'hFFFF);
        chk("negate_neg", {15'd0, is_negative}, 16'd1);
        apply(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 2'd1);
        step("zero_y_or");
        chk("zero_y_or_lit", output_result, 16'h1234);

        apply(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2'd0);
        step("op_and");
        chk("op_and_lit", output_result, 16'h0000);
        apply(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2'd1);
        step("op_or");
        chk("op_or_lit", output_result, 16'h0FFF);
        apply(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2'd2);
        step("op_add");
        chk("op_add_lit", output_result, 16'h0FFF);
        apply(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 2'd3);
        step("op_sub");
        chk("op_sub_lit", output_result, 16'hF1E1);
        chk("op_sub_neg", {15'd0, is_negative}, 16'd1);

        // Wrap and overflow boundaries
        apply(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd2);
        step("add_ovf");
        chk("add_ovf_lit", output_result, 16'h8000);
        apply(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd2);
        step("add_wrap");
        chk("add_wrap_lit", output_result, 16'h0000);
        apply(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd3);
        step("sub_ovf");
        chk("sub_ovf_lit", output_result, 16'h7FFF);
        apply(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 2'd2);
        step("ovf_before_neg");
        apply(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0);
        step("and_no_ovf");
`ifdef LUNA_ALU_OVERFLOW_EN
        apply(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'd2);
        step("ovf_lit_step");
        chk("ovf_lit", {15'd0, is_overflow}, 16'd1);
`endif

        // Back-to-back random operations, one per cycle
        for (int i = 0; i < 24; i++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom));
            step("rand");
        end

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
